// File: rtl/fft_bin_reader.sv
`timescale 1ns/1ps
// fft_bin_reader: sweeps the 8-point FFT select, buffers every bin, then streams
// them out over valid/ready with index and |re|+|im| magnitude.
module fft_bin_reader #(
  parameter int SEL_LAT = 1,
  parameter int DW      = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [2:0]         fft_sel,
  input  logic [DW-1:0]      fft_yr,
  input  logic [DW-1:0]      fft_yi,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_idx,
  output logic [DW-1:0]      out_re,
  output logic [DW-1:0]      out_im,
  output logic [DW:0]        out_mag,
  output logic               busy,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, SCAN, STREAM} state_t;
  state_t r_state;
  logic [2:0] r_sel, r_ptr;
  logic r_issued, r_valid, r_busy, r_done;
  logic [DW-1:0] r_re, r_im;
  logic [DW:0] r_mag;
  logic [2*DW-1:0] r_buf [8];
  logic w_v0, w_cv, w_last_cap, w_hs;
  logic [2:0] w_ci, w_ld_idx;
  logic [2*DW-1:0] w_ent;
  logic [DW-1:0] w_ere, w_eim;
  logic [DW:0] w_rx, w_ix, w_ra, w_ia, w_mag;
  // an issue slot is live until bin 7 has been put on fft_sel once
  assign w_v0 = (r_state == SCAN) && !r_issued;
  generate
    if (SEL_LAT == 0) begin : g_comb
      assign w_cv = w_v0;
      assign w_ci = r_sel;
    end else begin : g_pipe
      logic [SEL_LAT-1:0]   r_pv;
      logic [3*SEL_LAT-1:0] r_pi;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          r_pv <= '0;
          r_pi <= '0;
        end else begin
          r_pv <= SEL_LAT'({r_pv, w_v0});
          r_pi <= (3*SEL_LAT)'({r_pi, r_sel});
        end
      assign w_cv = r_pv[SEL_LAT-1];
      assign w_ci = r_pi[3*SEL_LAT-1 -: 3];
    end
  endgenerate
  assign w_last_cap = w_cv && (w_ci == 3'd7);
  assign w_hs       = (r_state == STREAM) && out_ready;
  assign w_ld_idx   = (r_state == SCAN) ? 3'd0 : r_ptr + 3'd1;
  assign w_ent      = r_buf[w_ld_idx];
  assign w_ere      = w_ent[2*DW-1:DW];
  assign w_eim      = w_ent[DW-1:0];
  assign w_rx       = {w_ere[DW-1], w_ere};
  assign w_ix       = {w_eim[DW-1], w_eim};
  assign w_ra       = w_rx[DW] ? -w_rx : w_rx;
  assign w_ia       = w_ix[DW] ? -w_ix : w_ix;
  assign w_mag      = w_ra + w_ia;
  always_ff @(posedge clk)
    if (w_cv) r_buf[w_ci] <= {fft_yr, fft_yi};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_ptr    <= '0;
      r_issued <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_re     <= '0;
      r_im     <= '0;
      r_mag    <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_state  <= SCAN;
          r_busy   <= 1'b1;
          r_sel    <= '0;
          r_issued <= 1'b0;
        end
      end else if (r_state == SCAN) begin
        if (r_sel == 3'd7) r_issued <= 1'b1;
        else r_sel <= r_sel + 3'd1;
        if (w_last_cap) begin
          r_state <= STREAM;
          r_valid <= 1'b1;
          r_ptr   <= '0;
          r_re    <= w_ere;
          r_im    <= w_eim;
          r_mag   <= w_mag;
        end
      end else if (w_hs) begin
        if (r_ptr == 3'd7) begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_sel   <= '0;
        end else begin
          r_ptr <= r_ptr + 3'd1;
          r_re  <= w_ere;
          r_im  <= w_eim;
          r_mag <= w_mag;
        end
      end
    end
  assign fft_sel   = r_sel;
  assign out_valid = r_valid;
  assign out_idx   = r_ptr;
  assign out_re    = r_re;
  assign out_im    = r_im;
  assign out_mag   = r_mag;
  assign busy      = r_busy;
  assign done      = r_done;
endmodule

// File: tb/tb_fft_bin_reader.sv
`timescale 1ns/1ps
// tb_fft_bin_reader: three readers (SEL_LAT 0/1/3) against delayed FFT stubs,
// checked against a table of hand-computed bins.
module tb_fft_bin_reader;
  localparam int LATS [3] = '{0, 1, 3};
  typedef struct {
    logic [2:0]        idx;
    logic signed [8:0] re;
    logic signed [8:0] im;
    logic [9:0]        mag;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0, special = 1'b0;
  logic [2:0] sel [3], idx [3];
  logic signed [8:0] yr [3], yi [3], re [3], im [3];
  logic [9:0] mag [3];
  logic valid [3], busy [3], done [3];
  vec_t tbl [8], tbl_sp [8];
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int L = LATS[g];
      logic [2:0] d1, d2, d3, ds;
      always @(posedge clk) begin
        d1 <= sel[g];
        d2 <= d1;
        d3 <= d2;
      end
      assign ds = (L == 0) ? sel[g] : (L == 1) ? d1 : d3;
      assign yr[g] = (special && ds == 3'd3) ? -9'sd256 : 9'(int'(ds) * 10);
      assign yi[g] = (special && ds == 3'd3) ? 9'sd255 : 9'(-int'(ds));
      fft_bin_reader #(.SEL_LAT(L), .DW(9)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .fft_sel(sel[g]),
        .fft_yr(yr[g]), .fft_yi(yi[g]), .out_valid(valid[g]), .out_ready(out_ready),
        .out_idx(idx[g]), .out_re(re[g]), .out_im(im[g]), .out_mag(mag[g]),
        .busy(busy[g]), .done(done[g])
      );
    end
  endgenerate
  task automatic chk(input string nm, input int g, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s lat%0d: got %0d, want %0d", nm, LATS[g], act, exp);
    end
  endtask
  task automatic sweep(input bit sp, input bit toggle, input bit pulse);
    int nxt [3], dn [3], lat [3];
    bit hs7 [3], stall [3];
    logic signed [8:0] sre [3], sim [3];
    logic [2:0] sidx [3];
    logic [9:0] smag [3];
    vec_t e;
    int cyc, post;
    for (int g = 0; g < 3; g++) begin
      nxt[g] = 0; dn[g] = 0; lat[g] = 0; hs7[g] = 0; stall[g] = 0;
    end
    special = sp;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    cyc = 0;
    post = 0;
    while (cyc < 300 && post < 4) begin
      @(posedge clk); #1;
      cyc++;
      start = pulse && (cyc == 3 || cyc == 12);
      out_ready = toggle ? (cyc % 3 == 1) : 1'b1;
      for (int g = 0; g < 3; g++) begin
        if (stall[g]) begin
          chk("stall_valid", g, valid[g], 1);
          chk("stall_idx", g, idx[g], sidx[g]);
          chk("stall_re", g, re[g], sre[g]);
          chk("stall_im", g, im[g], sim[g]);
          chk("stall_mag", g, mag[g], smag[g]);
        end
        chk("done", g, done[g], hs7[g]);
        if (done[g]) begin
          dn[g]++;
          lat[g] = cyc;
          chk("sel_idle", g, sel[g], 0);
          chk("busy_idle", g, busy[g], 0);
        end
        hs7[g] = 0;
        stall[g] = 0;
        if (valid[g]) begin
          chk("busy_stream", g, busy[g], 1);
          if (out_ready) begin
            if (nxt[g] < 8) begin
              e = sp ? tbl_sp[nxt[g]] : tbl[nxt[g]];
              chk("idx", g, idx[g], e.idx);
              chk("re", g, re[g], e.re);
              chk("im", g, im[g], e.im);
              chk("mag", g, mag[g], e.mag);
            end else chk("extra_bin", g, nxt[g], 7);
            hs7[g] = (idx[g] == 3'd7);
            nxt[g]++;
          end else begin
            stall[g] = 1;
            sidx[g] = idx[g]; sre[g] = re[g]; sim[g] = im[g]; smag[g] = mag[g];
          end
        end
      end
      if (dn[0] > 0 && dn[1] > 0 && dn[2] > 0) post++;
    end
    start = 1'b0;
    for (int g = 0; g < 3; g++) begin
      chk("done_count", g, dn[g], 1);
      chk("bins", g, nxt[g], 8);
      if (!toggle) chk("latency", g, lat[g], 17 + LATS[g]);
    end
  endtask
  initial begin
    for (int i = 0; i < 8; i++)
      tbl[i] = '{3'(i), 9'sd0, 9'sd0, 10'd0};
    tbl[1] = '{3'd1, 9'sd10, -9'sd1, 10'd11};
    tbl[2] = '{3'd2, 9'sd20, -9'sd2, 10'd22};
    tbl[3] = '{3'd3, 9'sd30, -9'sd3, 10'd33};
    tbl[4] = '{3'd4, 9'sd40, -9'sd4, 10'd44};
    tbl[5] = '{3'd5, 9'sd50, -9'sd5, 10'd55};
    tbl[6] = '{3'd6, 9'sd60, -9'sd6, 10'd66};
    tbl[7] = '{3'd7, 9'sd70, -9'sd7, 10'd77};
    tbl_sp = tbl;
    tbl_sp[3] = '{3'd3, -9'sd256, 9'sd255, 10'd511};
    #3;
    for (int g = 0; g < 3; g++) begin
      chk("rst_sel", g, sel[g], 0);
      chk("rst_valid", g, valid[g], 0);
      chk("rst_idx", g, idx[g], 0);
      chk("rst_re", g, re[g], 0);
      chk("rst_im", g, im[g], 0);
      chk("rst_mag", g, mag[g], 0);
      chk("rst_busy", g, busy[g], 0);
      chk("rst_done", g, done[g], 0);
    end
    #10 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    sweep(1'b0, 1'b0, 1'b0);
    sweep(1'b1, 1'b0, 1'b0);
    sweep(1'b0, 1'b1, 1'b0);
    sweep(1'b0, 1'b0, 1'b1);
    sweep(1'b0, 1'b0, 1'b0);
    begin
      int w;
      special = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      w = 0;
      while (!(valid[1] && idx[1] == 3'd4) && w < 100) begin
        @(posedge clk); #1;
        w++;
      end
      chk("rst_wait_idx4", 1, w < 100, 1);
      #2 rst_n = 1'b0;
      #1;
      for (int g = 0; g < 3; g++) begin
        chk("abort_valid", g, valid[g], 0);
        chk("abort_busy", g, busy[g], 0);
        chk("abort_sel", g, sel[g], 0);
        chk("abort_done", g, done[g], 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      for (int g = 0; g < 3; g++) chk("post_rst_done", g, done[g], 0);
    end
    sweep(1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
